alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the 8-bit ALU interface (ctrl[3:0]/x/y -> out/carry).
//  Accepts 16-bit instructions over valid/ready and reads operands from a local 8x8 register file.
//  Drives the combinational ALU for one cycle, writes the result back, and returns it on a response handshake.
//  Sits between a testbench/CPU front end and an unmodified combinational ALU instance.
// PARAMETERS
//  DATA_W   8   operand/result width; must equal ALU width (8)
//  NREG     8   register-file entries (addresses 3 bits)
//  INSTR_W  16  instruction word width
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst_n      in   1   synchronous, active-low reset
//  in_valid   in   1   instruction offered
//  in_ready   out  1   block can accept instruction
//  in_instr   in   16  [15:12]op [11:9]rd [8:6]rs [5:3]rt; LDI: imm=[7:0]
//  alu_ctrl   out  4   to ALU ctrl
//  alu_x      out  8   to ALU x = rf[rs]
//  alu_y      out  8   to ALU y = rf[rt]
//  alu_out    in   8   from ALU result
//  alu_carry  in   1   from ALU carry
//  rsp_valid  out  1   result available
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  8   written-back value
//  rsp_carry  out  1   carry flag after this instruction
//  rsp_rd     out  3   destination register written
//  dbg_raddr  in   3   debug read address
//  dbg_rdata  out  8   rf[dbg_raddr], combinational
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, rf all 0, carry flag 0, rsp_valid=0, rsp_* 0; alu_ctrl=4'hF, alu_x=alu_y=0.
//  FSM states and transitions:
//   IDLE: in_ready=1. On in_valid&in_ready, latch instr; op!=4'hF -> EXEC, op==4'hF (LDI) -> RESP.
//   EXEC (1 cycle): drive alu_ctrl=op, alu_x=rf[rs], alu_y=rf[rt]. At clock end, write rf[rd]<=alu_out.
//    Ops 0000/0001 also set carry<=alu_carry; all other ops leave carry unchanged. -> RESP.
//   LDI: rf[rd]<=imm at the accept edge; carry unchanged.
//   RESP: rsp_valid=1 and rsp_* stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE.
//  Outside EXEC: alu_ctrl=4'hF, alu_x=alu_y=0 (ALU default yields 0; no operand toggling).
//  Latency: ALU op accepted at edge N -> EXEC cycle N+1 -> rsp_valid from cycle N+2. LDI: rsp_valid from N+1.
//  Throughput: 3 cycles min per ALU op, 2 per LDI. in_ready=0 in EXEC/RESP; no overlap.
//  Opcodes 1101-1110 are issued to the ALU unmodified; rd receives alu_out (0 from ALU).
//  rd==rs or rd==rt is legal: operands are read before the write.
//  rf write is visible on dbg_rdata and to the next instruction from cycle N+2.
//  rsp_data = value written to rd. rsp_carry = carry flag after the write.
//  Reset mid-operation: EXEC/RESP abort, pending response is lost, rf is cleared.
//  in_instr is sampled only at the accept edge; changes while in_ready=0 are ignored.
// CONFIGURATION
//  ALU_FLAGS_EN defined: adds output rsp_zero (1 = rsp_data==0) and output sticky_carry.
//   sticky_carry: OR of all carries since reset, cleared only by reset.
//  ALU_FLAGS_EN undefined: neither port exists; all other behaviour identical.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD=4'h0 ... OP_EQ=4'hC, OP_LDI=4'hF), state encoding
//   (IDLE/EXEC/RESP), instruction field slice constants.
//  Sub-module alu_regfile: NREG x DATA_W, 2 combinational read ports + dbg read port, 1 sync write port,
//   synchronous active-low clear.
//  Top holds FSM, instruction latch, carry/flag regs, response regs.
// TESTING (bench instantiates the real combinational ALU on the alu_* ports)
//  LDI r1=0x7F, LDI r2=0x01, ADD r3,r1,r2 -> EXEC: ctrl=0, x=7F, y=01; rsp_data=0x80, rsp_carry=0, rf[3]=0x80.
//  LDI r4=0x00, LDI r5=0x01, SUB r6,r4,r5 -> rsp_data=0xFF, rsp_carry=1.
//   Then AND r7,r6,r5 -> rsp_data=0x01, rsp_carry stays 1.
//  LDI r1=0x03, LDI r2=0x81, SLL (op 7) r3,r1,r2 -> alu_x=03, alu_y=81, rsp_data=0x08.
//  Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, in_ready=0 throughout;
//   rsp_ready=1 -> IDLE next cycle, in_ready=1.
//  Reset in EXEC: rst_n=0 one edge -> rsp_valid=0, dbg_rdata=0 for all addresses, alu_ctrl=F, in_ready=1.
//  Op 4'hD with rd=2 -> rf[2]=0x00, carry unchanged.
//   With ALU_FLAGS_EN: rsp_zero=1, sticky_carry retains prior 1.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
// Optional flag outputs are enabled with ALU_FLAGS_EN.
package alu_issue_ctrl_pkg;

   localparam int DATA_W  = 8;
   localparam int NREG    = 8;
   localparam int INSTR_W = 16;
   localparam int RA_W    = 3;

   typedef logic [3:0] op_t;

   localparam op_t OP_ADD = 4'h0;
   localparam op_t OP_SUB = 4'h1;
   localparam op_t OP_AND = 4'h2;
   localparam op_t OP_OR  = 4'h3;
   localparam op_t OP_XOR = 4'h4;
   localparam op_t OP_NOT = 4'h5;
   localparam op_t OP_NOR = 4'h6;
   localparam op_t OP_SLL = 4'h7;
   localparam op_t OP_SRL = 4'h8;
   localparam op_t OP_SRA = 4'h9;
   localparam op_t OP_ROL = 4'hA;
   localparam op_t OP_LT  = 4'hB;
   localparam op_t OP_EQ  = 4'hC;
   localparam op_t OP_LDI = 4'hF;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS_HI  = 8;
   localparam int RS_LO  = 6;
   localparam int RT_HI  = 5;
   localparam int RT_LO  = 3;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   function automatic logic has_carry(input op_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction request and result response handshakes.
// master = front end, slave = issue controller.
interface alu_issue_ctrl_if;
   import alu_issue_ctrl_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [DATA_W-1:0]  rsp_data;
   logic               rsp_carry;
   logic [RA_W-1:0]    rsp_rd;

   modport master (
      output in_valid, in_instr, rsp_ready,
      input  in_ready, rsp_valid, rsp_data,
      input  rsp_carry, rsp_rd
   );

   modport slave (
      input  in_valid, in_instr, rsp_ready,
      output in_ready, rsp_valid, rsp_data,
      output rsp_carry, rsp_rd
   );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// NREG x DATA_W register file: two operand reads, one debug
// read, one synchronous write, synchronous active-low clear.
module alu_issue_ctrl_regfile
   import alu_issue_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [RA_W-1:0]   waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [RA_W-1:0]   raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [RA_W-1:0]   raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [RA_W-1:0]   dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   logic [DATA_W-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a   = mem[raddr_a];
   assign rdata_b   = mem[raddr_b];
   assign dbg_rdata = mem[dbg_raddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving an external combinational 8-bit ALU.
// ALU_FLAGS_EN adds rsp_zero and sticky_carry outputs.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   alu_issue_ctrl_if.slave   bus,
   output logic [3:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_x,
   output logic [DATA_W-1:0] alu_y,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_carry,
   input  logic [RA_W-1:0]   dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
`ifdef ALU_FLAGS_EN
   ,
   output logic              rsp_zero,
   output logic              sticky_carry
`endif
);

   state_t state_q, state_d;

   op_t             op_q;
   logic [RA_W-1:0] rd_q, rs_q, rt_q;
   logic            carry_q;

   logic [DATA_W-1:0] rsp_data_q;
   logic [RA_W-1:0]   rsp_rd_q;

   logic              accept, ldi_acc, is_exec;
   op_t               in_op;
   logic              we;
   logic [RA_W-1:0]   waddr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata_a, rdata_b;

   assign in_op   = bus.in_instr[OP_HI:OP_LO];
   assign accept  = bus.in_valid && bus.in_ready;
   assign ldi_acc = accept && (in_op == OP_LDI);
   assign is_exec = (state_q == S_EXEC);

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_carry = carry_q;
   assign bus.rsp_rd    = rsp_rd_q;

   // ALU sees a quiet default opcode and zero operands unless executing
   assign alu_ctrl = is_exec ? op_q    : OP_LDI;
   assign alu_x    = is_exec ? rdata_a : '0;
   assign alu_y    = is_exec ? rdata_b : '0;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept)
               state_d = (in_op == OP_LDI) ? S_RESP
                                           : S_EXEC;
         end
         S_EXEC: state_d = S_RESP;
         S_RESP: begin
            if (bus.rsp_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      we    = 1'b0;
      waddr = rd_q;
      wdata = alu_out;
      unique case (1'b1)
         ldi_acc: begin
            we    = 1'b1;
            waddr = bus.in_instr[RD_HI:RD_LO];
            wdata = bus.in_instr[IMM_HI:IMM_LO];
         end
         is_exec: we = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         op_q       <= OP_LDI;
         rd_q       <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         carry_q    <= 1'b0;
         rsp_data_q <= '0;
         rsp_rd_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= in_op;
            rd_q <= bus.in_instr[RD_HI:RD_LO];
            rs_q <= bus.in_instr[RS_HI:RS_LO];
            rt_q <= bus.in_instr[RT_HI:RT_LO];
         end
         if (we) begin
            rsp_data_q <= wdata;
            rsp_rd_q   <= waddr;
         end
         if (is_exec && has_carry(op_q))
            carry_q <= alu_carry;
      end
   end

`ifdef ALU_FLAGS_EN
   logic sticky_q;

   always_ff @(posedge clk) begin
      if (!rst_n)
         sticky_q <= 1'b0;
      else if (is_exec && has_carry(op_q) && alu_carry)
         sticky_q <= 1'b1;
   end

   assign rsp_zero     = (rsp_data_q == '0);
   assign sticky_carry = sticky_q;
`endif

   alu_issue_ctrl_regfile u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .raddr_a   (rs_q),
      .rdata_a   (rdata_a),
      .raddr_b   (rt_q),
      .rdata_b   (rdata_b),
      .dbg_raddr (dbg_raddr),
      .dbg_rdata (dbg_rdata)
   );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU
// on the alu_* ports; flag checks follow ALU_FLAGS_EN.
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   logic [3:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_x, alu_y, alu_out;
   logic              alu_carry;
   logic [RA_W-1:0]   dbg_raddr;
   logic [DATA_W-1:0] dbg_rdata;
`ifdef ALU_FLAGS_EN
   logic rsp_zero, sticky_carry;
`endif

   int n_vec = 0;
   int n_err = 0;

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .alu_ctrl     (alu_ctrl),
      .alu_x        (alu_x),
      .alu_y        (alu_y),
      .alu_out      (alu_out),
      .alu_carry    (alu_carry),
      .dbg_raddr    (dbg_raddr),
      .dbg_rdata    (dbg_rdata)
`ifdef ALU_FLAGS_EN
      ,
      .rsp_zero     (rsp_zero),
      .sticky_carry (sticky_carry)
`endif
   );

   always #5 clk = ~clk;

   // Reference combinational ALU; unused codes return 0
   logic [15:0] rot;
   always_comb begin
      alu_out   = '0;
      alu_carry = 1'b0;
      rot       = {alu_y, alu_y} << alu_x[2:0];
      case (alu_ctrl)
         OP_ADD: {alu_carry, alu_out} =
                    {1'b0, alu_x} + {1'b0, alu_y};
         OP_SUB: {alu_carry, alu_out} =
                    {1'b0, alu_x} - {1'b0, alu_y};
         OP_AND: alu_out = alu_x & alu_y;
         OP_OR:  alu_out = alu_x | alu_y;
         OP_XOR: alu_out = alu_x ^ alu_y;
         OP_NOT: alu_out = ~alu_x;
         OP_NOR: alu_out = ~(alu_x | alu_y);
         OP_SLL: alu_out = alu_y << alu_x[2:0];
         OP_SRL: alu_out = alu_y >> alu_x[2:0];
         OP_SRA: alu_out = $signed(alu_y) >>> alu_x[2:0];
         OP_ROL: alu_out = rot[15:8];
         OP_LT:  alu_out = {7'd0, alu_x < alu_y};
         OP_EQ:  alu_out = {7'd0, alu_x == alu_y};
         default: alu_out = '0;
      endcase
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(
      input op_t op, input logic [2:0] rd,
      input logic [2:0] rs, input logic [2:0] rt);
      return {op, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] mk_ldi(
      input logic [2:0] rd, input logic [7:0] imm);
      return {OP_LDI, rd, 1'b0, imm};
   endfunction

   task automatic send(input logic [15:0] ins);
      int t = 0;
      while (!bus.in_ready && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.in_ready)
         chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_instr = 16'($urandom);
   endtask

   task automatic ldi(input logic [2:0] rd,
                      input logic [7:0] imm);
      send(mk_ldi(rd, imm));
      chk("ldi_valid", 32'(bus.rsp_valid), 32'd1);
      chk("ldi_data", 32'(bus.rsp_data), 32'(imm));
      chk("ldi_rd", 32'(bus.rsp_rd), 32'(rd));
      @(posedge clk); #1;
   endtask

   task automatic alu_op(
      input op_t op, input logic [2:0] rd,
      input logic [2:0] rs, input logic [2:0] rt,
      input logic [7:0] ex_x, input logic [7:0] ex_y,
      input logic [7:0] ex_d, input logic ex_c);
      send(mk(op, rd, rs, rt));
      chk("exec_ctrl", 32'(alu_ctrl), 32'(op));
      chk("exec_x", 32'(alu_x), 32'(ex_x));
      chk("exec_y", 32'(alu_y), 32'(ex_y));
      chk("exec_nvalid", 32'(bus.rsp_valid), 32'd0);
      chk("exec_nready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rsp_data", 32'(bus.rsp_data), 32'(ex_d));
      chk("rsp_carry", 32'(bus.rsp_carry), 32'(ex_c));
      chk("rsp_rd", 32'(bus.rsp_rd), 32'(rd));
      chk("resp_ctrl", 32'(alu_ctrl), 32'hF);
      dbg_raddr = rd;
      #1;
      chk("rf_wb", 32'(dbg_rdata), 32'(ex_d));
      @(posedge clk); #1;
   endtask

   task automatic chk_rf_clear;
      for (int i = 0; i < NREG; i++) begin
         dbg_raddr = 3'(i);
         #1;
         chk("rf_clear", 32'(dbg_rdata), 32'd0);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.rsp_ready = 1'b1;
      dbg_raddr     = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_rsp_carry", 32'(bus.rsp_carry), 32'd0);
      chk("rst_rsp_rd", 32'(bus.rsp_rd), 32'd0);
      chk("rst_alu_ctrl", 32'(alu_ctrl), 32'hF);
      chk("rst_alu_x", 32'(alu_x), 32'd0);
      chk("rst_alu_y", 32'(alu_y), 32'd0);
      chk_rf_clear();

      ldi(3'd1, 8'h7F);
      ldi(3'd2, 8'h01);
      alu_op(OP_ADD, 3'd3, 3'd1, 3'd2,
             8'h7F, 8'h01, 8'h80, 1'b0);

      ldi(3'd4, 8'h00);
      ldi(3'd5, 8'h01);
      alu_op(OP_SUB, 3'd6, 3'd4, 3'd5,
             8'h00, 8'h01, 8'hFF, 1'b1);
      alu_op(OP_AND, 3'd7, 3'd6, 3'd5,
             8'hFF, 8'h01, 8'h01, 1'b1);

      ldi(3'd1, 8'h03);
      ldi(3'd2, 8'h81);
      alu_op(OP_SLL, 3'd3, 3'd1, 3'd2,
             8'h03, 8'h81, 8'h08, 1'b1);

      // unassigned opcode: result 0, carry kept
      alu_op(4'hD, 3'd2, 3'd1, 3'd2,
             8'h03, 8'h81, 8'h00, 1'b1);
`ifdef ALU_FLAGS_EN
      send(mk_ldi(3'd0, 8'h00));
      chk("rsp_zero", 32'(rsp_zero), 32'd1);
      chk("sticky", 32'(sticky_carry), 32'd1);
      @(posedge clk); #1;
`endif

      // destination aliases both sources
      alu_op(OP_ADD, 3'd1, 3'd1, 3'd1,
             8'h03, 8'h03, 8'h06, 1'b0);
`ifdef ALU_FLAGS_EN
      chk("sticky_hold", 32'(sticky_carry), 32'd1);
`endif

      bus.rsp_ready = 1'b0;
      send(mk_ldi(3'd0, 8'h5A));
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_data", 32'(bus.rsp_data), 32'h5A);
         chk("bp_rd", 32'(bus.rsp_rd), 32'd0);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
      chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);

      send(mk(OP_ADD, 3'd3, 3'd1, 3'd2));
      chk("pre_rst_exec", 32'(alu_ctrl), 32'(OP_ADD));
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_ctrl", 32'(alu_ctrl), 32'hF);
      chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_carry", 32'(bus.rsp_carry), 32'd0);
`ifdef ALU_FLAGS_EN
      chk("mid_rst_sticky", 32'(sticky_carry), 32'd0);
`endif
      chk_rf_clear();
      @(posedge clk); #1;
      chk("post_rst_idle", 32'(bus.rsp_valid), 32'd0);

      ldi(3'd6, 8'h42);
      dbg_raddr = 3'd6;
      #1;
      chk("post_rst_ldi", 32'(dbg_rdata), 32'h42);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
